seg7_capture: RTL and testbench
===============================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The block SHALL have one parameter, STABLE_CYCLES, default 4 (legal 2..255): the number of consecutive clock edges a scan slot must hold unchanged before it is captured.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 segs7  input  7  segment bus, active-low, bit6..bit0 = g,f,e,d,c,b,a.
REQ-005 Anodes  input  4  digit enables, active-low; Anodes[i] low selects digit i.
REQ-006 period  input  1  decimal-point segment, active-low; lit means negative-sign marker.
REQ-007 Value  output  16  captured hex digits; digit i occupies Value[4i+3:4i].
REQ-008 DigitValid  output  4  bit i high once digit i has been captured since reset.
REQ-009 DpMask  output  4  bit i is the lit state of period at the last capture of digit i.
REQ-010 FrameDone  output  1  one-cycle pulse when all four digits have been captured in the current frame.
REQ-011 BadPattern  output  1  one-cycle pulse when a stable slot carries a segment pattern outside the decode table.
REQ-012 MultiAnode  output  1  one-cycle pulse when a sampled Anodes value has more than one bit low.

Function
REQ-013 The block SHALL register {Anodes, segs7, period} into a sample register S every cycle.
REQ-014 Stability counter C SHALL clear when the incoming bus differs from S, and SHALL otherwise increment, saturating at STABLE_CYCLES-1.
REQ-015 The FSM SHALL have states IDLE, SETTLE and HOLD.
- IDLE: no single anode active.
- SETTLE: exactly one anode low; counting stability.
- HOLD: slot captured; waiting for the bus to change.
REQ-016 Transitions from any state:
- All Anodes high -> IDLE.
- Two or more Anodes low -> IDLE, with MultiAnode pulsed once on entry to that condition.
- Bus change with exactly one anode low -> SETTLE with C = 0.
REQ-017 In SETTLE, when C reaches STABLE_CYCLES-1, the block SHALL perform the capture and enter HOLD; a bus held constant across STABLE_CYCLES consecutive edges is therefore captured at the STABLE_CYCLES-th edge.
REQ-018 Capture SHALL decode the lit pattern (~segs7, as gfedcba hex) as follows:
- 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
- 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F
REQ-019 On a valid decode for digit i, capture SHALL write the Value nibble, set DigitValid[i], write DpMask[i] = ~period, and set frame-mask bit i.
REQ-020 On an undecodable pattern, capture SHALL pulse BadPattern, leave Value, DigitValid, DpMask and the frame mask unchanged, and still enter HOLD.
REQ-021 HOLD SHALL NOT recapture the slot, however long it stays stable; only a bus change re-arms capture.
REQ-022 When the frame mask becomes 1111, FrameDone SHALL pulse on the following cycle and the mask SHALL clear in that same cycle.
REQ-023 Recapturing a digit already present in the frame mask SHALL update Value but SHALL NOT advance the frame.
REQ-024 A bus change during SETTLE SHALL restart counting for the new slot; no partial capture is allowed.
REQ-025 All outputs SHALL be registered; Value, DigitValid and DpMask SHALL change only at capture edges.

Reset
REQ-026 While reset is high, the block SHALL asynchronously force the following:
- FSM = IDLE, C = 0, S = all ones, frame mask = 0.
- Value = 0, DigitValid = 0, DpMask = 0.
- FrameDone = 0, BadPattern = 0, MultiAnode = 0.
REQ-027 Reset asserted mid-SETTLE SHALL abort the pending capture; after release the block SHALL need a full STABLE_CYCLES-edge stable interval before any capture.

Verification
REQ-028 The bench SHALL cover these directed scenarios (STABLE_CYCLES = 4):
- Anodes=1110, segs7=~7'h4F (lit 0x4F), period=1, held 4 edges -> Value[3:0]=3, DigitValid=0001, DpMask=0000, no pulses.
- Scan digits 0..3 with 1,2,3,4 (period=0 on digit 3), 8 cycles each -> exactly one FrameDone pulse; Value=16'h4321; DpMask=1000.
- Digit 2 lit pattern 0x00, held 6 cycles -> a single BadPattern pulse; Value and DigitValid unchanged.
- Anodes=1100 for 5 cycles -> a single MultiAnode pulse; no capture.
- Digit 1 bus changing every 3 cycles -> no capture. Then reset pulsed at edge 2 of a stable slot -> all outputs 0, and capture occurs only 4 edges after release.

Source files
------------

// File: rtl/seg7_capture.sv
// Recovers the hex digits shown on a multiplexed, active-low seven-segment display
// by sampling the scan bus and capturing each digit slot once it has settled.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segs7,
  input  logic [3:0]  Anodes,
  input  logic        period,
  output logic [15:0] Value,
  output logic [3:0]  DigitValid,
  output logic [3:0]  DpMask,
  output logic        FrameDone,
  output logic        BadPattern,
  output logic        MultiAnode
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

  state_t      state_q, state_d;
  logic [11:0] samp_q, samp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  dp_q, dp_d;
  logic        frame_done_q, frame_done_d;
  logic        bad_q, bad_d;
  logic        multi_q, multi_d;

  logic [11:0] bus_in;
  logic        changed;
  logic [2:0]  lows_in, lows_prev;
  logic [4:0]  dec;

  function automatic logic [2:0] count_lows(input logic [3:0] a);
    count_lows = 3'(!a[0]) + 3'(!a[1]) + 3'(!a[2]) + 3'(!a[3]);
  endfunction

  // Lit gfedcba pattern to {valid, nibble}; anything else is not a hex glyph.
  function automatic logic [4:0] decode(input logic [6:0] lit);
    case (lit)
      7'h3F:   decode = {1'b1, 4'h0};
      7'h06:   decode = {1'b1, 4'h1};
      7'h5B:   decode = {1'b1, 4'h2};
      7'h4F:   decode = {1'b1, 4'h3};
      7'h66:   decode = {1'b1, 4'h4};
      7'h6D:   decode = {1'b1, 4'h5};
      7'h7D:   decode = {1'b1, 4'h6};
      7'h07:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h6F:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h7C:   decode = {1'b1, 4'hB};
      7'h39:   decode = {1'b1, 4'hC};
      7'h5E:   decode = {1'b1, 4'hD};
      7'h79:   decode = {1'b1, 4'hE};
      7'h71:   decode = {1'b1, 4'hF};
      default: decode = 5'b0;
    endcase
  endfunction

  always_comb begin
    bus_in       = {Anodes, segs7, period};
    changed      = (bus_in != samp_q);
    lows_in      = count_lows(Anodes);
    lows_prev    = count_lows(samp_q[11:8]);
    dec          = decode(~segs7);
    samp_d       = bus_in;
    cnt_d        = changed ? 8'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1);
    multi_d      = (lows_in >= 3'd2) && (lows_prev < 3'd2);
    frame_done_d = (mask_q == 4'hF);
    mask_d       = (mask_q == 4'hF) ? 4'h0 : mask_q;
    state_d      = state_q;
    value_d      = value_q;
    valid_d      = valid_q;
    dp_d         = dp_q;
    bad_d        = 1'b0;

    // The capture edge is the one at which the counter would reach its saturation value.
    if (lows_in != 3'd1) begin
      state_d = IDLE;
    end else if (changed) begin
      state_d = SETTLE;
    end else if (state_q == SETTLE && cnt_q == CNT_ARM) begin
      state_d = HOLD;
      if (dec[4]) begin
        for (int i = 0; i < 4; i++) begin
          if (!Anodes[i]) begin
            value_d[4*i +: 4] = dec[3:0];
            valid_d[i]        = 1'b1;
            dp_d[i]           = ~period;
            mask_d[i]         = 1'b1;
          end
        end
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      samp_q       <= '1;
      cnt_q        <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      valid_q      <= '0;
      dp_q         <= '0;
      frame_done_q <= 1'b0;
      bad_q        <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      bad_q        <= bad_d;
      multi_q      <= multi_d;
    end
  end

  assign Value      = value_q;
  assign DigitValid = valid_q;
  assign DpMask     = dp_q;
  assign FrameDone  = frame_done_q;
  assign BadPattern = bad_q;
  assign MultiAnode = multi_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Drives seg7_capture with directed scan scenarios and random scan traffic, checking
// every cycle against a run-length model of the display bus.
module tb_seg7_capture;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  segs7 = 7'h7F;
  logic [3:0]  Anodes = 4'hF;
  logic        period = 1'b1;
  logic [15:0] Value;
  logic [3:0]  DigitValid, DpMask;
  logic        FrameDone, BadPattern, MultiAnode;

  int compareCount = 0;
  int errorCount = 0;
  int frameSeen, badSeen, multiSeen;

  logic [6:0]  litTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [11:0] mPrev;
  int          mRun;
  bit          mArmed;
  logic [15:0] mValue;
  logic [3:0]  mValid, mDp, mMask;
  bit          mFrame, mBad, mMulti;

  seg7_capture #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .segs7(segs7), .Anodes(Anodes), .period(period),
    .Value(Value), .DigitValid(DigitValid), .DpMask(DpMask),
    .FrameDone(FrameDone), .BadPattern(BadPattern), .MultiAnode(MultiAnode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPrev = '1; mRun = 0; mArmed = 0;
    mValue = '0; mValid = '0; mDp = '0; mMask = '0;
    mFrame = 0; mBad = 0; mMulti = 0;
  endtask

  // A slot is captured once, when the same bus value with one digit selected
  // has been seen at N consecutive edges.
  task automatic modelEdge(input logic [3:0] a, input logic [6:0] s, input logic p);
    logic [11:0] b;
    int lows, prevLows, digit, glyph;
    b = {a, s, p};
    lows = $countones(~a);
    prevLows = $countones(~mPrev[11:8]);
    mMulti = (lows >= 2) && (prevLows < 2);
    mFrame = (mMask == 4'hF);
    if (mFrame) mMask = 4'h0;
    mBad = 0;
    if (b != mPrev) begin
      mRun = 1;
      mArmed = (lows == 1);
    end else begin
      mRun++;
    end
    if (lows == 1 && mArmed && mRun == N) begin
      mArmed = 0;
      digit = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) digit = i;
      glyph = -1;
      for (int k = 0; k < 16; k++) if (litTab[k] == ~s) glyph = k;
      if (glyph >= 0) begin
        mValue[digit*4 +: 4] = 4'(glyph);
        mValid[digit] = 1'b1;
        mDp[digit] = ~p;
        mMask[digit] = 1'b1;
      end else begin
        mBad = 1;
      end
    end
    mPrev = b;
  endtask

  task automatic compareAll();
    checkOutput("Value", 32'(Value), 32'(mValue));
    checkOutput("DigitValid", 32'(DigitValid), 32'(mValid));
    checkOutput("DpMask", 32'(DpMask), 32'(mDp));
    checkOutput("FrameDone", 32'(FrameDone), 32'(mFrame));
    checkOutput("BadPattern", 32'(BadPattern), 32'(mBad));
    checkOutput("MultiAnode", 32'(MultiAnode), 32'(mMulti));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) modelReset();
    else modelEdge(Anodes, segs7, period);
    #1;
    compareAll();
    if (FrameDone) frameSeen++;
    if (BadPattern) badSeen++;
    if (MultiAnode) multiSeen++;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input logic p, input int cycles);
    Anodes = a; segs7 = s; period = p;
    for (int c = 0; c < cycles; c++) tick();
  endtask

  task automatic clearSeen();
    frameSeen = 0; badSeen = 0; multiSeen = 0;
  endtask

  initial begin
    modelReset();
    clearSeen();
    #1;
    compareAll();
    tick();
    tick();
    reset = 1'b0;

    clearSeen();
    applyStimulus(4'b1110, ~7'h4F, 1'b1, N);
    checkOutput("s1_digit0", 32'(Value[3:0]), 32'h3);
    checkOutput("s1_valid", 32'(DigitValid), 32'b0001);
    checkOutput("s1_dp", 32'(DpMask), 32'b0000);
    checkOutput("s1_pulses", 32'(frameSeen + badSeen + multiSeen), 32'd0);

    clearSeen();
    for (int d = 0; d < 4; d++)
      applyStimulus(~(4'b0001 << d), ~litTab[d+1], (d == 3) ? 1'b0 : 1'b1, 8);
    checkOutput("s2_frames", 32'(frameSeen), 32'd1);
    checkOutput("s2_value", 32'(Value), 32'h4321);
    checkOutput("s2_dp", 32'(DpMask), 32'b1000);

    clearSeen();
    applyStimulus(4'b1011, 7'h7F, 1'b1, 6);
    checkOutput("s3_bad", 32'(badSeen), 32'd1);
    checkOutput("s3_value", 32'(Value), 32'h4321);
    checkOutput("s3_valid", 32'(DigitValid), 32'hF);

    clearSeen();
    applyStimulus(4'b1100, ~litTab[7], 1'b1, 5);
    checkOutput("s4_multi", 32'(multiSeen), 32'd1);
    checkOutput("s4_value", 32'(Value), 32'h4321);

    for (int k = 0; k < 6; k++)
      applyStimulus(4'b1101, (k % 2) ? ~litTab[7] : ~litTab[9], 1'b1, 3);
    checkOutput("s5_nocap", 32'(Value), 32'h4321);

    applyStimulus(4'b1101, ~litTab[5], 1'b1, 2);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("s5_rst_value", 32'(Value), 32'h0);
    checkOutput("s5_rst_valid", 32'(DigitValid), 32'h0);
    checkOutput("s5_rst_pulses", 32'({FrameDone, BadPattern, MultiAnode, DpMask}), 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(4'b1101, ~litTab[5], 1'b1, N - 1);
    checkOutput("s5_early", 32'(DigitValid), 32'h0);
    tick();
    checkOutput("s5_cap_valid", 32'(DigitValid), 32'b0010);
    checkOutput("s5_cap_value", 32'(Value), 32'h0050);

    for (int r = 0; r < 400; r++) begin
      logic [3:0] a;
      logic [6:0] s;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = 4'hF;
      else if (sel == 1) a = 4'($urandom);
      else a = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) s = 7'($urandom);
      else s = ~litTab[$urandom_range(0, 15)];
      applyStimulus(a, s, 1'($urandom), $urandom_range(1, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
